// File: rtl/spad_stream_reader.sv
// Scratchpad burst reader: walks RAM addresses with a stride and streams the
// words out through a 2-entry valid/ready FIFO.
module spad_stream_reader #(
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_BITWIDTH-1:0] base_addr,
  input  logic [ADDR_BITWIDTH:0]   length,
  input  logic [ADDR_BITWIDTH-1:0] stride,
  output logic [ADDR_BITWIDTH-1:0] ram_addr,
  input  logic [DATA_BITWIDTH-1:0] ram_q,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;
  logic [ADDR_BITWIDTH:0]   rem_q, rem_d;
  logic [ADDR_BITWIDTH-1:0] stride_q, stride_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [DATA_BITWIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_BITWIDTH-1:0] slot1_q, slot1_d;
  logic                     zdone_q, zdone_d;
  logic                     pop;
  logic                     issue;

  assign pop   = (cnt_q != 2'd0) && out_ready;
  assign issue = (state_q == READ) && ((cnt_q < 2'd2) || pop);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    stride_d = stride_q;
    zdone_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          rem_d    = length;
          stride_d = stride;
          if (length != '0) state_d = READ;
          else              zdone_d = 1'b1;
        end
      end
      READ: begin
        if (issue) begin
          addr_d = addr_q + stride_q;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (ADDR_BITWIDTH+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot 0 is always the head; slot 1 only fills when the head is occupied.
  always_comb begin
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case (1'b1)
      issue && pop: begin
        if (cnt_q == 2'd2) begin
          slot0_d = slot1_q;
          slot1_d = ram_q;
        end else begin
          slot0_d = ram_q;
        end
      end
      issue && !pop: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) slot0_d = ram_q;
        else               slot1_d = ram_q;
      end
      !issue && pop: begin
        cnt_d   = cnt_q - 2'd1;
        slot0_d = slot1_q;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      stride_q <= '0;
      cnt_q    <= 2'd0;
      slot0_q  <= '0;
      slot1_q  <= '0;
      zdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      stride_q <= stride_d;
      cnt_q    <= cnt_d;
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      zdone_q  <= zdone_d;
    end
  end

  assign ram_addr  = addr_q;
  assign out_data  = slot0_q;
  assign out_valid = (cnt_q != 2'd0);
  assign busy      = (state_q != IDLE);
  assign done      = zdone_q || ((state_q == DRAIN) && (cnt_q == 2'd0));

endmodule

// File: tb/tb_spad_stream_reader.sv
// Bench for spad_stream_reader: table bursts, reset corner cases and random
// bursts checked against a queue of expected words computed from RAM contents.
module tb_spad_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] base_addr;
  logic [7:0] length;
  logic [6:0] stride;
  logic [6:0] ram_addr;
  logic [7:0] ram_q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  logic [7:0] ram [128];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign ram_q = ram[ram_addr];

  spad_stream_reader #(
    .DATA_BITWIDTH(8),
    .ADDR_BITWIDTH(7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .stride   (stride),
    .ram_addr (ram_addr),
    .ram_q    (ram_q),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [6:0] b;
    logic [7:0] l;
    logic [6:0] s;
    int         mode;
    bit         inj;
    logic [7:0] ef;
    logic [7:0] el;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // mode 0: ready always high; 1: pattern 1,0,0,1,1,0; 2: random
  task automatic run_burst(input logic [6:0] b, input logic [7:0] l,
                           input logic [6:0] s, input int mode,
                           input bit inj, input bit ends,
                           input logic [7:0] ef, input logic [7:0] el);
    logic [7:0] q[$];
    logic [5:0] pat;
    logic [7:0] prev_d, got_first, got_last;
    bit   prev_stall, fin, got_any, any_valid;
    int   dones, done_k, first_k, budget;
    pat = 6'b011001;
    prev_d = '0; got_first = '0; got_last = '0;
    prev_stall = 0; fin = 0; got_any = 0; any_valid = 0;
    dones = 0; done_k = 0; first_k = 0;
    budget = 6 * int'(l) + 20;
    for (int i = 0; i < int'(l); i++)
      q.push_back(ram[(int'(b) + i * int'(s)) % 128]);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l; stride = s;
    out_ready = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      start = inj && (k == 3);
      if (start) begin
        base_addr = 7'd50; length = 8'd5; stride = 7'd1;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = pat[(k - 1) % 6];
        default: out_ready = (($urandom % 4) != 0) || (k % 4 == 0);
      endcase
      @(negedge clk);
      if (k == 1) begin
        chk("load_addr", int'(ram_addr), int'(b));
        chk("busy_k1", int'(busy), int'(l != 0));
      end
      if (prev_stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(prev_d));
      end
      if (out_valid) begin
        if (!any_valid) first_k = k;
        any_valid = 1;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("extra_word", int'(out_data), -1);
        else chk("data", int'(out_data), int'(q.pop_front()));
        if (!got_any) got_first = out_data;
        got_last = out_data;
        got_any = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      if (done) begin
        dones++;
        done_k = k;
      end
      if (dones > 0 && k == done_k + 1) begin
        chk("busy_after_done", int'(busy), 0);
        fin = 1;
        break;
      end
    end
    out_ready = 1'b0;
    start = 1'b0;
    chk("finished", int'(fin), 1);
    chk("leftover", q.size(), 0);
    chk("done_count", dones, 1);
    if (l == 0) chk("zero_valid", int'(any_valid), 0);
    if (mode == 0) begin
      chk("done_cycle", done_k, (l == 0) ? 1 : int'(l) + 2);
      if (l != 0) chk("latency", first_k, 2);
    end
    if (ends && l != 0) begin
      chk("first_word", int'(got_first), int'(ef));
      chk("last_word", int'(got_last), int'(el));
    end
  endtask

  vec_t tbl [7];

  initial begin
    tbl[0] = '{7'd3,   8'd4,   7'd1, 0, 1'b0, 8'h13, 8'h16};
    tbl[1] = '{7'd126, 8'd3,   7'd3, 0, 1'b0, 8'h8E, 8'h14};
    tbl[2] = '{7'd10,  8'd6,   7'd1, 1, 1'b0, 8'h1A, 8'h1F};
    tbl[3] = '{7'd0,   8'd0,   7'd1, 0, 1'b0, 8'h00, 8'h00};
    tbl[4] = '{7'd20,  8'd5,   7'd2, 0, 1'b1, 8'h24, 8'h2C};
    tbl[5] = '{7'd0,   8'd128, 7'd1, 0, 1'b0, 8'h10, 8'h8F};
    tbl[6] = '{7'd7,   8'd3,   7'd0, 1, 1'b0, 8'h17, 8'h17};

    for (int i = 0; i < 128; i++) ram[i] = 8'(i + 16);
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    stride = '0; out_ready = 1'b0;
    #2;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_addr", int'(ram_addr), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i])
      run_burst(tbl[i].b, tbl[i].l, tbl[i].s, tbl[i].mode,
                tbl[i].inj, 1'b1, tbl[i].ef, tbl[i].el);

    // Abort a burst with both FIFO slots full.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 7'd40; length = 8'd8; stride = 7'd1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_valid", int'(out_valid), 1);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_addr", int'(ram_addr), 0);
    @(negedge clk);
    chk("mid_rst_done2", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", int'(done), 0);
    chk("post_rst_valid", int'(out_valid), 0);
    run_burst(7'd0, 8'd2, 7'd1, 0, 1'b0, 1'b1, 8'h10, 8'h11);

    for (int i = 0; i < 128; i++) ram[i] = 8'($urandom);
    for (int n = 0; n < 25; n++) begin
      logic [7:0] rl;
      rl = (n == 12) ? 8'd128 : 8'($urandom_range(0, 24));
      run_burst(7'($urandom), rl, 7'($urandom), 2, 1'($urandom),
                1'b0, 8'h00, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spad_stream_reader.md
SPAD_STREAM_READER -- requirements
Module: spad_stream_reader

Interface
REQ-001 SHALL have parameter DATA_BITWIDTH, default 8, RAM word width.
REQ-002 SHALL have parameter ADDR_BITWIDTH, default 7, RAM address width (depth 2^ADDR_BITWIDTH).
REQ-003 SHALL use one clock; reset is asynchronous and active-high. Ports clk and rst, as the codebase names them.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  async active-high reset.
REQ-006 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_BITWIDTH  first word address, sampled with start.
REQ-008 length  input  ADDR_BITWIDTH+1  word count 0..2^ADDR_BITWIDTH, sampled with start.
REQ-009 stride  input  ADDR_BITWIDTH  address increment per word, sampled with start.
REQ-010 ram_addr  output  ADDR_BITWIDTH  registered read address to the RAM port.
REQ-011 ram_q  input  DATA_BITWIDTH  RAM read data, combinationally valid for the current ram_addr.
REQ-012 out_data  output  DATA_BITWIDTH  stream data, head of the output FIFO.
REQ-013 out_valid  output  1  stream valid.
REQ-014 out_ready  input  1  consumer ready.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse when a burst completes.

Function
REQ-017 SHALL implement the FSM IDLE -> READ -> DRAIN -> IDLE.
- IDLE: start && length!=0 -> READ. start && length==0 -> stays IDLE and pulses done the next cycle.
- READ: after the last word issues -> DRAIN.
- DRAIN: FIFO empty -> IDLE, with done asserted that cycle.
REQ-018 On start in IDLE, SHALL load ram_addr<=base_addr, remaining<=length, and latch stride, all registered.
REQ-019 SHALL hold a 2-entry output FIFO. pop = out_valid && out_ready. out_valid = (count!=0). out_data = head entry.
REQ-020 In READ, issue = (count<2) || pop. On issue:
- push ram_q at the current ram_addr.
- ram_addr <= ram_addr+stride, modulo 2^ADDR_BITWIDTH (wrap-around, no error).
- remaining decrements.
REQ-021 A simultaneous push and pop with count==2 SHALL keep count at 2 with no data loss. A simultaneous push and pop with count==1 SHALL keep count at 1, data in order.
REQ-022 Latency: start at edge N -> first word on out_data with out_valid=1 after edge N+2. Sustained throughput is 1 word/cycle while out_ready=1.
REQ-023 Data SHALL leave in issue order. No word SHALL be dropped or duplicated under any out_ready pattern.
REQ-024 out_valid, once high, SHALL stay high with out_data stable until pop.
REQ-025 start while busy SHALL be ignored; the inputs it carries are not sampled.
REQ-026 done SHALL be high exactly one cycle per accepted start, and busy SHALL be low in the cycle after done.
REQ-027 ram_addr SHALL hold its value while stalled (no issue).

Reset
REQ-028 rst high SHALL immediately force:
- state IDLE
- busy=0, done=0, out_valid=0
- out_data=0, ram_addr=0
- FIFO count 0, remaining 0
REQ-029 Reset during READ or DRAIN SHALL abort the burst, discarding FIFO contents, with no done pulse. The first start after rst deasserts SHALL behave as from power-up.

Verification
REQ-030 Basic burst:
- Stimulus: RAM[i]=i+0x10, base=3, length=4, stride=1, out_ready=1.
- Response: 0x13, 0x14, 0x15, 0x16 on consecutive cycles from N+2; done 1 cycle after the last pop.
REQ-031 Stride with wrap-around:
- Stimulus: base=126, stride=3, length=3.
- Response: ram_addr sequence 126, 1, 4; outputs RAM[126], RAM[1], RAM[4].
REQ-032 Backpressure:
- Stimulus: length=6, out_ready toggling 1,0,0,1,1,0,...
- Response: exactly 6 pops in order; count never exceeds 2; out_data stable while out_valid && !out_ready.
REQ-033 Zero length:
- Stimulus: start with length=0.
- Response: done pulses the next cycle; out_valid stays 0; busy stays 0.
REQ-034 Start while busy:
- Stimulus: second start (base=50) mid-burst.
- Response: ignored; only the first burst's data appears; a single done.
REQ-035 Reset mid-burst:
- Stimulus: rst asserted during READ with count=2.
- Response: all outputs 0 in the same cycle; no done. A following burst with base=0, length=2 returns RAM[0], RAM[1].
